// File: rtl/stream_sdram_writer_if.sv
// Wishbone bundles for stream_sdram_writer.
//   stream_wb_if : pixel stream port. Carries cyc/stb/we/adr/dat from the master
//                  and ack/err/rty back from the slave.
//   sdram_wb_if  : SDRAM write port. Carries cyc/stb/we/adr/dat/sel from the
//                  master and ack back from the slave. There is no err/rty,
//                  because the SDRAM side always acks.
interface stream_wb_if;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic        ack, err, rty;
  modport master (output cyc, stb, we, adr, dat, input ack, err, rty);
  modport slave  (input cyc, stb, we, adr, dat, output ack, err, rty);
endinterface

interface sdram_wb_if;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        ack;
  modport master (output cyc, stb, we, adr, dat, sel, input ack);
  modport slave  (input cyc, stb, we, adr, dat, sel, output ack);
endinterface

// File: rtl/stream_sdram_writer.sv
// stream_sdram_writer
// Accepts 32-bit pixel writes on a Wishbone slave port and buffers them in a
// DEPTH-entry FIFO. It replays them as single Wishbone writes to SDRAM at
// linear frame-buffer addresses. A write to stream address 0 marks start of
// frame and restarts addressing at BASE_ADR. The address also wraps by itself
// after HDISP*VDISP pixels.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   s                : stream slave (ack = accepted write, err/rty tied 0)
//   m                : SDRAM master (single writes, sel = 4'hF)
//   level            : FIFO occupancy, 0..DEPTH
module stream_sdram_writer #(
  parameter int          DEPTH    = 8,
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  stream_wb_if.slave             s,
  sdram_wb_if.master             m,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW   = $clog2(DEPTH);
  localparam int NPIX = HDISP * VDISP;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] LAST  = PW'(NPIX - 1);
  localparam logic [AW:0]   FULLV = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;
  typedef struct packed {
    logic        sof;
    logic [31:0] dat;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          r_full;
  logic [PW-1:0] r_pix;
  state_t        r_state;
  logic          r_wr;

  ent_t          w_head;
  logic          w_push, w_pop;
  logic [AW:0]   w_level_nxt;
  logic [PW-1:0] w_idx;

  // The full flag is registered, so a pop does not open space for a push in
  // the same cycle. This keeps s.ack free of any dependence on m.ack.
  assign w_push      = s.cyc & s.stb & s.we & ~r_full;
  assign w_pop       = r_wr & m.ack;
  assign w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign w_head = r_mem[r_rptr];
  assign w_idx  = w_head.sof ? '0 : r_pix;

  assign s.ack = w_push;
  assign s.err = 1'b0;
  assign s.rty = 1'b0;

  // Master outputs decode from the state register and the FIFO head only.
  // They read as zero outside WRITE.
  assign m.cyc = r_wr;
  assign m.stb = r_wr;
  assign m.we  = r_wr;
  assign m.sel = {4{r_wr}};
  assign m.dat = r_wr ? w_head.dat : 32'h0;
  assign m.adr = r_wr ? BASE_ADR + (32'(w_idx) << 2) : 32'h0;
  assign level = r_level;

  // Stored data needs no reset. Only the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr] <= '{sof: (s.adr == 32'h0), dat: s.dat};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULLV);
    end
  end

  // WRITE is entered only with a non-empty FIFO. It is left only when the
  // level after this cycle's pop and push would be zero. Therefore a pop never
  // happens on an empty FIFO.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_wr    <= 1'b0;
      r_pix   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_level != '0) begin
            r_state <= WRITE;
            r_wr    <= 1'b1;
          end
        end
        WRITE: begin
          if (m.ack) begin
            r_pix <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
            if (w_level_nxt == '0) begin
              r_state <= IDLE;
              r_wr    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end
endmodule
